// File: rtl/board_rst_seq.sv
// Board reset sequencer: synchronizes the button and PLL lock, debounces the button,
// and releases the demo system reset a fixed number of cycles after conditions are good.
module board_rst_seq #(
   parameter int SyncStages     = 2,
   parameter int DebounceCycles = 50000,
   parameter int HoldCycles     = 64
) (
   input  logic       clk_sys_i,
   input  logic       rst_sys_i,
   input  logic       btn_rst_ni,
   input  logic       pll_locked_i,
   input  logic       sw_rst_req_i,
   output logic       rst_sys_no,
   output logic [1:0] rst_cause_o,
   output logic [7:0] rst_count_o
);

   localparam int DbWidth   = $clog2(DebounceCycles + 1);
   localparam int HoldWidth = $clog2(HoldCycles + 1);
   localparam logic [DbWidth-1:0]   DbLast   = DbWidth'(DebounceCycles - 1);
   localparam logic [HoldWidth-1:0] HoldLast = HoldWidth'(HoldCycles - 1);

   localparam logic [1:0] WAIT_LOCK = 2'd0;
   localparam logic [1:0] HOLD      = 2'd1;
   localparam logic [1:0] RUN       = 2'd2;

   localparam logic [1:0] CAUSE_BTN  = 2'd1;
   localparam logic [1:0] CAUSE_LOCK = 2'd2;
   localparam logic [1:0] CAUSE_SW   = 2'd3;

   logic [SyncStages-1:0] btn_sync;
   logic [SyncStages-1:0] lock_sync;
   logic                  btn_s;
   logic                  lock_s;
   logic                  db_state;
   logic [DbWidth-1:0]    db_cnt;
   logic [1:0]            state;
   logic [1:0]            next_state;
   logic [HoldWidth-1:0]  hold_cnt;
   logic                  take_exit;
   logic                  exit_run;
   logic [1:0]            exit_cause;
   logic                  sw_block;

   assign btn_s  = btn_sync[SyncStages-1];
   assign lock_s = lock_sync[SyncStages-1];

   always_ff @(posedge clk_sys_i) begin
      if (rst_sys_i) begin
         btn_sync  <= '1;
         lock_sync <= '0;
      end else begin
         btn_sync  <= {btn_sync[SyncStages-2:0], btn_rst_ni};
         lock_sync <= {lock_sync[SyncStages-2:0], pll_locked_i};
      end
   end

   // Flip only after DebounceCycles consecutive samples that disagree with the accepted state.
   always_ff @(posedge clk_sys_i) begin
      if (rst_sys_i) begin
         db_state <= 1'b1;
         db_cnt   <= '0;
      end else if (btn_s == db_state) begin
         db_cnt <= '0;
      end else if (db_cnt == DbLast) begin
         db_state <= btn_s;
         db_cnt   <= '0;
      end else begin
         db_cnt <= db_cnt + DbWidth'(1);
      end
   end

   always_comb begin
      next_state = state;
      take_exit  = 1'b0;
      exit_run   = 1'b0;
      exit_cause = rst_cause_o;
      case (state)
         WAIT_LOCK: begin
            if (lock_s && db_state) next_state = HOLD;
         end
         HOLD: begin
            if (!lock_s) begin
               next_state = WAIT_LOCK;
               take_exit  = 1'b1;
               exit_cause = CAUSE_LOCK;
            end else if (!db_state) begin
               next_state = WAIT_LOCK;
               take_exit  = 1'b1;
               exit_cause = CAUSE_BTN;
            end else if (hold_cnt == HoldLast) begin
               next_state = RUN;
            end
         end
         RUN: begin
            if (!lock_s) begin
               next_state = WAIT_LOCK;
               take_exit  = 1'b1;
               exit_cause = CAUSE_LOCK;
            end else if (!db_state) begin
               next_state = WAIT_LOCK;
               take_exit  = 1'b1;
               exit_cause = CAUSE_BTN;
            end else if (sw_rst_req_i && !sw_block) begin
               next_state = WAIT_LOCK;
               take_exit  = 1'b1;
               exit_cause = CAUSE_SW;
            end
            exit_run = take_exit;
         end
         default: next_state = WAIT_LOCK;
      endcase
   end

   // A request still high when RUN is left stays blocked until it drops, so one long
   // request produces exactly one reset.
   always_ff @(posedge clk_sys_i) begin
      if (rst_sys_i) begin
         state       <= WAIT_LOCK;
         hold_cnt    <= '0;
         rst_sys_no  <= 1'b0;
         rst_cause_o <= 2'd0;
         rst_count_o <= 8'd0;
         sw_block    <= 1'b0;
      end else begin
         state      <= next_state;
         rst_sys_no <= (next_state == RUN);
         if (state == WAIT_LOCK) begin
            hold_cnt <= '0;
         end else if (state == HOLD) begin
            hold_cnt <= hold_cnt + HoldWidth'(1);
         end
         if (take_exit) begin
            rst_cause_o <= exit_cause;
         end
         if (exit_run && (rst_count_o != 8'hFF)) begin
            rst_count_o <= rst_count_o + 8'd1;
         end
         if (!sw_rst_req_i) begin
            sw_block <= 1'b0;
         end else if (exit_run) begin
            sw_block <= 1'b1;
         end
      end
   end

endmodule
